// File: rtl/ppi_pkg.sv
// Shared definitions for the PPI bus controller: FSM encoding, port selects,
// control-word layout and the phase-length helper.
package ppi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } ppi_state_e;

   localparam logic [1:0] PORT_A    = 2'd0;
   localparam logic [1:0] PORT_B    = 2'd1;
   localparam logic [1:0] PORT_C    = 2'd2;
   localparam logic [1:0] PORT_CTRL = 2'd3;

   localparam int CTRL_MODE_BIT = 7;

   // The timer counts down to zero, so a phase of N cycles loads N-1.
   function automatic logic [3:0] phase_load(input int unsigned cycles);
      return 4'(cycles - 1);
   endfunction

endpackage

// File: rtl/ppi_cycle_timer.sv
// Loadable 4-bit down-counter; done is high while the count sits at zero.
module ppi_cycle_timer (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic       done
);

   logic [3:0] count;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_value;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign done = (count == 4'd0);

endmodule

// File: rtl/ppi_bus_ctrl.sv
// Request/response front end driving an 8255-style PPI with setup/strobe/hold phases.
// Define PPI_BUS_CTRL_SHADOW_EN to keep a shadow copy of the last control-register write.
module ppi_bus_ctrl
   import ppi_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [1:0] req_sel,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [7:0] ppi_data_o,
   output logic       ppi_data_oe,
   input  logic [7:0] ppi_data_i,
   output logic       CS_low,
   output logic       RD_low,
   output logic       WR_low,
   output logic [1:0] PortSelect,
   output logic [7:0] ctrl_shadow
);

   ppi_state_e state, next_state;

   logic       accept;
   logic       txn_write;
   logic [1:0] txn_sel;
   logic [7:0] txn_wdata;
   logic       cur_write;
   logic [1:0] cur_sel;
   logic [7:0] cur_wdata;
   logic       timer_load;
   logic [3:0] timer_value;
   logic       timer_done;
   logic       txn_done;
   logic [7:0] rd_capture;

   logic       cs_low_d;
   logic       rd_low_d;
   logic       wr_low_d;
   logic       oe_d;
   logic [1:0] sel_d;
   logic [7:0] data_d;

   assign accept   = req_valid & req_ready;
   assign txn_done = (state == ST_HOLD) && timer_done;

   // On the accept edge the request fields are not yet latched, so outputs use the live inputs.
   assign cur_write = accept ? req_write : txn_write;
   assign cur_sel   = accept ? req_sel   : txn_sel;
   assign cur_wdata = accept ? req_wdata : txn_wdata;

   ppi_cycle_timer u_timer (
      .Clk        (Clk),
      .Reset      (Reset),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= ST_IDLE;
         txn_write <= 1'b0;
         txn_sel   <= PORT_A;
         txn_wdata <= 8'h00;
      end else begin
         state <= next_state;
         if (accept) begin
            txn_write <= req_write;
            txn_sel   <= req_sel;
            txn_wdata <= req_wdata;
         end
      end
   end

   always_comb begin
      next_state  = state;
      timer_load  = 1'b0;
      timer_value = 4'd0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               next_state  = ST_SETUP;
               timer_load  = 1'b1;
               timer_value = phase_load(SETUP_CYC);
            end
         end
         ST_SETUP: begin
            if (timer_done) begin
               next_state  = ST_STROBE;
               timer_load  = 1'b1;
               timer_value = phase_load(STROBE_CYC);
            end
         end
         ST_STROBE: begin
            if (timer_done) begin
               next_state  = ST_HOLD;
               timer_load  = 1'b1;
               timer_value = phase_load(HOLD_CYC);
            end
         end
         ST_HOLD: begin
            if (timer_done) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Pin values for the coming cycle; a control-register read stays off the bus entirely.
   always_comb begin
      cs_low_d = 1'b1;
      rd_low_d = 1'b1;
      wr_low_d = 1'b1;
      oe_d     = 1'b0;
      sel_d    = PORT_A;
      data_d   = 8'h00;
      if (next_state != ST_IDLE) begin
         sel_d    = cur_sel;
         cs_low_d = !cur_write && (cur_sel == PORT_CTRL);
         if (cur_write) begin
            oe_d     = 1'b1;
            data_d   = cur_wdata;
            wr_low_d = (next_state != ST_STROBE);
         end else if (cur_sel != PORT_CTRL) begin
            rd_low_d = (next_state != ST_STROBE);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         CS_low      <= 1'b1;
         RD_low      <= 1'b1;
         WR_low      <= 1'b1;
         PortSelect  <= PORT_A;
         ppi_data_oe <= 1'b0;
         ppi_data_o  <= 8'h00;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
      end else begin
         CS_low      <= cs_low_d;
         RD_low      <= rd_low_d;
         WR_low      <= wr_low_d;
         PortSelect  <= sel_d;
         ppi_data_oe <= oe_d;
         ppi_data_o  <= data_d;
         req_ready   <= (next_state == ST_IDLE);
         rsp_valid   <= txn_done;
      end
   end

   // Read data is sampled as the strobe ends but only published when the cycle completes.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_capture <= 8'h00;
         rsp_rdata  <= 8'h00;
      end else begin
         if ((state == ST_STROBE) && timer_done) begin
            rd_capture <= (txn_sel == PORT_CTRL) ? 8'h00 : ppi_data_i;
         end
         if (txn_done && !txn_write) begin
            rsp_rdata <= rd_capture;
         end
      end
   end

`ifdef PPI_BUS_CTRL_SHADOW_EN
   logic [7:0] shadow_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         shadow_q <= 8'h00;
      end else if (txn_done && txn_write && (txn_sel == PORT_CTRL)) begin
         shadow_q <= txn_wdata;
      end
   end

   assign ctrl_shadow = shadow_q;
`else
   assign ctrl_shadow = 8'h00;
`endif

endmodule
